// File: rtl/slow_tick_bcd_display.sv
// slow_tick_bcd_display: synchronises a slow square wave and detects its rising
// edges. Each edge steps a 2-digit BCD up/down counter, and the count drives a
// multiplexed, active-low 7-segment display with two digits in use.
module slow_tick_bcd_display #(
  parameter int MAX_COUNT   = 99,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       enable,
  input  logic       up_down,
  input  logic       clear,
  output logic [7:0] count_bcd,
  output logic       tick,
  output logic       wrap,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int              REF_W    = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [3:0]      MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0]      MAX_ONES = 4'(MAX_COUNT % 10);

  // Any code above 9 blanks the digit.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  logic [2:0]       sync_q, sync_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             digit_sel_q, digit_sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             edge_det;

  // Edge detection and BCD counter next state: clear beats a counting edge.
  always_comb begin
    sync_d   = {sync_q[1:0], slow_clk};
    edge_det = sync_q[1] & ~sync_q[2];
    tick_d   = edge_det;
    wrap_d   = 1'b0;
    tens_d   = tens_q;
    ones_d   = ones_q;
    if (clear) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (edge_det && enable) begin
      if (up_down) begin
        if (tens_q == MAX_TENS && ones_q == MAX_ONES) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (tens_q == 4'd0 && ones_q == 4'd0) begin
          tens_d = MAX_TENS;
          ones_d = MAX_ONES;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  // Refresh timer and digit multiplexing; an/seg lag digit_sel by one cycle.
  always_comb begin
    ref_cnt_d   = ref_cnt_q + REF_W'(1);
    digit_sel_d = digit_sel_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d   = '0;
      digit_sel_d = ~digit_sel_q;
    end
    an_d  = digit_sel_q ? 4'b1101 : 4'b1110;
    seg_d = enc(digit_sel_q ? tens_q : ones_q);
  end

  // State registers; the sync chain resets high so a high input is not an edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q      <= 3'b111;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      ref_cnt_q   <= '0;
      digit_sel_q <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
    end else begin
      sync_q      <= sync_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      ref_cnt_q   <= ref_cnt_d;
      digit_sel_q <= digit_sel_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign count_bcd = {tens_q, ones_q};
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_slow_tick_bcd_display.sv
// Bench for slow_tick_bcd_display: two instances (terminal 99 and 59) share the
// stimulus and are compared against an integer reference count.
module tb_slow_tick_bcd_display;

  logic       clk = 1'b0;
  logic       reset, slow_clk, enable, up_down, clear;
  logic [7:0] count99, count59;
  logic       tick99, tick59, wrap99, wrap59;
  logic [3:0] an99, an59;
  logic [6:0] seg99, seg59;

  int total = 0;
  int bad   = 0;

  int m99, m59;
  bit ew99, ew59;

  logic       t_pre, t_on, t_post, w_on, w_post, w59_on;
  logic [7:0] c99, c59;

  logic [6:0] enc_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  slow_tick_bcd_display #(.MAX_COUNT(99), .REFRESH_DIV(4)) dut (
    .clock_in(clk), .reset(reset), .slow_clk(slow_clk), .enable(enable),
    .up_down(up_down), .clear(clear), .count_bcd(count99), .tick(tick99),
    .wrap(wrap99), .an(an99), .seg(seg99));

  slow_tick_bcd_display #(.MAX_COUNT(59), .REFRESH_DIV(4)) dut59 (
    .clock_in(clk), .reset(reset), .slow_clk(slow_clk), .enable(enable),
    .up_down(up_down), .clear(clear), .count_bcd(count59), .tick(tick59),
    .wrap(wrap59), .an(an59), .seg(seg59));

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int nxt(input int c, input int mx, input bit up);
    if (up) return (c == mx) ? 0 : c + 1;
    return (c == 0) ? mx : c - 1;
  endfunction

  // Reference model for one detected edge.
  task automatic model_edge(input bit clr, input bit en, input bit ud);
    ew99 = 0;
    ew59 = 0;
    if (clr) begin
      m99 = 0;
      m59 = 0;
    end else if (en) begin
      ew99 = ud ? (m99 == 99) : (m99 == 0);
      ew59 = ud ? (m59 == 59) : (m59 == 0);
      m99  = nxt(m99, 99, ud);
      m59  = nxt(m59, 59, ud);
    end
  endtask

  // One slow_clk pulse (4 cycles high), optional clear in the edge cycle.
  task automatic do_edge(input logic clr, input int low_cycles);
    slow_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    t_pre = tick99;
    clear = clr;
    @(negedge clk);
    t_on   = tick99;
    c99    = count99;
    w_on   = wrap99;
    c59    = count59;
    w59_on = wrap59;
    clear  = 1'b0;
    @(negedge clk);
    t_post   = tick99;
    w_post   = wrap99;
    slow_clk = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp_an;
    reset = 1; slow_clk = 1; enable = 1; up_down = 1; clear = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({count99, tick99, wrap99, an99, seg99} !== {8'h00, 1'b0, 1'b0, 4'b1111, 7'b1111111} ||
        {count59, tick59, wrap59, an59, seg59} !== {8'h00, 1'b0, 1'b0, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL reset_values got %h %b %b %b %b want 00 0 0 1111 1111111",
               count99, tick99, wrap99, an99, seg99);
    end
    reset = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_an = (((n - 1) / 4) % 2 == 0) ? 4'b1110 : 4'b1101;
      total++;
      if (tick99 !== 1'b0 || tick59 !== 1'b0 || count99 !== 8'h00) begin
        bad++;
        $display("FAIL reset_release cycle %0d tick %b count %h want 0 00", n, tick99, count99);
      end
      total++;
      if (an99 !== exp_an || seg99 !== enc_tab[0] || an59 !== exp_an) begin
        bad++;
        $display("FAIL reset_display cycle %0d an %b seg %b want %b %b", n, an99, seg99, exp_an, enc_tab[0]);
      end
    end
    slow_clk = 0;
    repeat (4) @(negedge clk);
    m99 = 0;
    m59 = 0;
  endtask

  task automatic test_count_up;
    enable = 1; up_down = 1;
    for (int i = 0; i < 12; i++) begin
      model_edge(0, 1, 1);
      do_edge(0, 4);
      total++;
      if ({t_pre, t_on, t_post} !== 3'b010) begin
        bad++; $display("FAIL up_tick edge %0d got %b want 010", i, {t_pre, t_on, t_post});
      end
      total++;
      if (c99 !== bcd(m99) || {w_on, w_post} !== {ew99, 1'b0}) begin
        bad++; $display("FAIL up_count edge %0d got %h w%b%b want %h w%b0", i, c99, w_on, w_post, bcd(m99), ew99);
      end
      total++;
      if (c59 !== bcd(m59) || w59_on !== ew59) begin
        bad++; $display("FAIL up_count59 edge %0d got %h w%b want %h w%b", i, c59, w59_on, bcd(m59), ew59);
      end
    end
    total++;
    if (count99 !== 8'h12) begin
      bad++; $display("FAIL up_twelve got %h want 12", count99);
    end
  endtask

  task automatic test_up_wrap;
    enable = 1; up_down = 1;
    for (int i = 0; i < 88; i++) begin
      model_edge(0, 1, 1);
      do_edge(0, 4);
      total++;
      if ({t_pre, t_on, t_post} !== 3'b010) begin
        bad++; $display("FAIL wrap_tick edge %0d got %b want 010", i, {t_pre, t_on, t_post});
      end
      total++;
      if (c99 !== bcd(m99) || {w_on, w_post} !== {ew99, 1'b0}) begin
        bad++; $display("FAIL wrap_count edge %0d got %h w%b%b want %h w%b0", i, c99, w_on, w_post, bcd(m99), ew99);
      end
      total++;
      if (c59 !== bcd(m59) || w59_on !== ew59) begin
        bad++; $display("FAIL wrap_count59 edge %0d got %h w%b want %h w%b", i, c59, w59_on, bcd(m59), ew59);
      end
    end
  endtask

  task automatic test_down_enable;
    for (int i = 0; i < 6; i++) begin
      enable  = (i == 0);
      up_down = 0;
      model_edge(0, enable, 0);
      do_edge(0, 5);
      total++;
      if ({t_pre, t_on, t_post} !== 3'b010) begin
        bad++; $display("FAIL down_tick edge %0d got %b want 010", i, {t_pre, t_on, t_post});
      end
      total++;
      if (c99 !== bcd(m99) || {w_on, w_post} !== {ew99, 1'b0}) begin
        bad++; $display("FAIL down_count edge %0d got %h w%b%b want %h w%b0", i, c99, w_on, w_post, bcd(m99), ew99);
      end
      total++;
      if (c59 !== bcd(m59) || w59_on !== ew59) begin
        bad++; $display("FAIL down_count59 edge %0d got %h w%b want %h w%b", i, c59, w59_on, bcd(m59), ew59);
      end
    end
  endtask

  task automatic test_clear;
    clear = 1;
    @(negedge clk);
    clear = 0;
    m99 = 0;
    m59 = 0;
    enable = 1; up_down = 1;
    for (int i = 0; i < 37; i++) begin
      model_edge(0, 1, 1);
      do_edge(0, 4);
    end
    total++;
    if (count99 !== 8'h37 || count59 !== 8'h37) begin
      bad++; $display("FAIL clear_setup got %h %h want 37 37", count99, count59);
    end
    model_edge(1, 1, 1);
    do_edge(1, 4);
    total++;
    if ({t_pre, t_on, t_post} !== 3'b010 || c99 !== 8'h00 || w_on !== 1'b0 || c59 !== 8'h00) begin
      bad++; $display("FAIL clear_edge got tick %b count %h wrap %b want 010 00 0",
                      {t_pre, t_on, t_post}, c99, w_on);
    end
  endtask

  task automatic test_refresh;
    logic [3:0] prev_an, cur_an, other_an, exp_an;
    logic [6:0] exp_seg;
    bit         found;
    enable = 1; up_down = 1;
    for (int i = 0; i < 42; i++) begin
      model_edge(0, 1, 1);
      do_edge(0, 4);
    end
    total++;
    if (count99 !== bcd(m99)) begin
      bad++; $display("FAIL refresh_setup got %h want %h", count99, bcd(m99));
    end
    prev_an = an99;
    found   = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (an99 !== prev_an) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL refresh_toggle timeout an stuck at %b want change within 10 cycles", an99);
    end
    cur_an   = an99;
    other_an = (cur_an == 4'b1110) ? 4'b1101 : 4'b1110;
    for (int i = 0; i < 16; i++) begin
      exp_an  = ((i / 4) % 2 == 0) ? cur_an : other_an;
      exp_seg = (exp_an == 4'b1110) ? enc_tab[m99 % 10] : enc_tab[m99 / 10];
      total++;
      if (an99 !== exp_an || seg99 !== exp_seg) begin
        bad++; $display("FAIL refresh cycle %0d an %b seg %b want %b %b", i, an99, seg99, exp_an, exp_seg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    bit r_clr, r_en, r_ud;
    for (int i = 0; i < 40; i++) begin
      r_clr   = ($urandom_range(0, 7) == 0);
      r_en    = ($urandom_range(0, 3) != 0);
      r_ud    = $urandom_range(0, 1);
      enable  = r_en;
      up_down = r_ud;
      model_edge(r_clr, r_en, r_ud);
      do_edge(r_clr, $urandom_range(4, 8));
      total++;
      if ({t_pre, t_on, t_post} !== 3'b010) begin
        bad++; $display("FAIL rand_tick edge %0d got %b want 010", i, {t_pre, t_on, t_post});
      end
      total++;
      if (c99 !== bcd(m99) || {w_on, w_post} !== {ew99, 1'b0}) begin
        bad++; $display("FAIL rand_count edge %0d got %h w%b%b want %h w%b0", i, c99, w_on, w_post, bcd(m99), ew99);
      end
      total++;
      if (c59 !== bcd(m59) || w59_on !== ew59) begin
        bad++; $display("FAIL rand_count59 edge %0d got %h w%b want %h w%b", i, c59, w59_on, bcd(m59), ew59);
      end
    end
  endtask

  task automatic test_reset_mid;
    enable = 1; up_down = 1;
    do_edge(0, 4);
    slow_clk = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    total++;
    if ({count99, tick99, wrap99, an99, seg99} !== {8'h00, 1'b0, 1'b0, 4'b1111, 7'b1111111} ||
        {count59, tick59, wrap59, an59, seg59} !== {8'h00, 1'b0, 1'b0, 4'b1111, 7'b1111111}) begin
      bad++;
      $display("FAIL reset_mid got %h %b %b %b %b want 00 0 0 1111 1111111",
               count99, tick99, wrap99, an99, seg99);
    end
    reset = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      total++;
      if (tick99 !== 1'b0 || count99 !== 8'h00) begin
        bad++; $display("FAIL reset_mid_partial cycle %0d tick %b count %h want 0 00", n, tick99, count99);
      end
    end
    slow_clk = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_up_wrap;
    test_down_enable;
    test_clear;
    test_refresh;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
